// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register file write-port arbiter between WB and the MD unit
// Optional statistics counters are built when REGFILE_ARB_STATS_EN is defined.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        md_valid,
  input  logic [4:0]  md_waddr,
  input  logic [31:0] md_wdata,
  output logic        md_ready,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_reg,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic [31:0] md_grant_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:1] busy;

  logic        wbq;
  logic        grant_md;
  logic        md_hs;
  logic [31:0] busy_all;
  logic [31:0] busy_next;

  assign wbq      = wb_we && (wb_waddr != 5'd0);
  assign busy_all = {busy, 1'b0};

  always_comb begin
    grant_md = 1'b0;
    case (state)
      IDLE:    grant_md = md_valid && !wbq;
      WAIT:    grant_md = md_valid && !wbq;
      FORCE:   grant_md = 1'b1;
      default: grant_md = 1'b0;
    endcase
  end

  // Every output is gated by reset so nothing reaches the register file while reset is held.
  always_comb begin
    md_ready = 1'b0;
    wb_stall = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (reset) begin
      md_ready = grant_md;
      wb_stall = (state == FORCE);
      if (grant_md) begin
        rf_we    = (md_waddr != 5'd0);
        rf_waddr = md_waddr;
        rf_wdata = md_wdata;
      end else begin
        rf_we    = wbq;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end
    end
  end

  assign md_hs   = md_valid && md_ready;
  assign rs_busy = reset && busy_all[rs_addr];
  assign rt_busy = reset && busy_all[rt_addr];

  // Set is applied after clear so an issue to the register being retired keeps it busy.
  always_comb begin
    busy_next = busy_all;
    if (md_hs) busy_next[md_waddr] = 1'b0;
    if (md_issue) busy_next[md_issue_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= '0;
    end else begin
      busy <= busy_next[31:1];
      case (state)
        IDLE: begin
          if (md_valid && wbq) begin
            state <= WAIT;
            cnt   <= 4'd1;
          end
        end
        WAIT: begin
          if (!md_valid || !wbq) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'(STARVE_LIMIT)) begin
            state <= FORCE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FORCE: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_grant_cnt <= 32'd0;
      stall_cnt    <= 32'd0;
    end else begin
      if (md_hs) md_grant_cnt <= md_grant_cnt + 32'd1;
      if (state == FORCE) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign md_grant_cnt = 32'd0;
  assign stall_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        md_valid;
  logic [4:0]  md_waddr;
  logic [31:0] md_wdata;
  logic        md_ready;
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic [31:0] md_grant_cnt;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .md_valid(md_valid), .md_waddr(md_waddr), .md_wdata(md_wdata), .md_ready(md_ready),
    .md_issue(md_issue), .md_issue_reg(md_issue_reg),
    .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .md_grant_cnt(md_grant_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic        stl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic we, input logic [4:0] a, input logic [31:0] d,
                          input logic rdy, input logic stl);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.rdy = rdy; e.stl = stl;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".rf_we"},    32'(rf_we),    32'(e.we));
      chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(e.addr));
      chk({tag, ".rf_wdata"}, rf_wdata,      e.data);
      chk({tag, ".md_ready"}, 32'(md_ready), 32'(e.rdy));
      chk({tag, ".wb_stall"}, 32'(wb_stall), 32'(e.stl));
    end
  endtask

  task automatic set_in(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we = wwe; wb_waddr = wa; wb_wdata = wd;
    md_valid = mv; md_waddr = ma; md_wdata = md;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    md_issue = 1'b0; md_issue_reg = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
    #2;
    chk("reset.md_ready", 32'(md_ready), 32'd0);
    chk("reset.rf_we",    32'(rf_we),    32'd0);
    chk("reset.stall_cnt", stall_cnt,    32'd0);
    next_cycle();
    reset = 1'b1;

    // MD alone gets the port in the same cycle
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h1234);
    push_exp(1'b1, 5'd8, 32'h1234, 1'b1, 1'b0);
    @(negedge clk); pop_check("md_only"); next_cycle();

    // Continuous WB traffic starves MD until a forced stall
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 5'd9, 32'hAAAA0000 + 32'(i), 1'b1, 5'd5, 32'h5555);
      push_exp(1'b1, 5'd9, 32'hAAAA0000 + 32'(i), 1'b0, 1'b0);
      @(negedge clk); pop_check("starve_wb"); next_cycle();
    end
    set_in(1'b1, 5'd9, 32'hAAAA0005, 1'b1, 5'd5, 32'h5555);
    push_exp(1'b1, 5'd5, 32'h5555, 1'b1, 1'b1);
    @(negedge clk); pop_check("starve_force"); next_cycle();
    set_in(1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, 32'd0);
    push_exp(1'b1, 5'd9, 32'hBBBB, 1'b0, 1'b0);
    @(negedge clk); pop_check("after_force");
`ifdef REGFILE_ARB_STATS_EN
    chk("stall_cnt_one", stall_cnt, 32'd1);
`else
    chk("stall_cnt_tied", stall_cnt, 32'd0);
`endif
    next_cycle();

    // WB to $0 never blocks MD
    set_in(1'b1, 5'd0, 32'hCCCC, 1'b1, 5'd6, 32'h6666);
    push_exp(1'b1, 5'd6, 32'h6666, 1'b1, 1'b0);
    @(negedge clk); pop_check("wb_zero"); next_cycle();

    // Scoreboard set, set-wins-over-clear, then clear
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    md_issue = 1'b1; md_issue_reg = 5'd17; rs_addr = 5'd17; rt_addr = 5'd0;
    push_exp(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk); pop_check("issue"); chk("busy_not_yet", 32'(rs_busy), 32'd0); next_cycle();
    md_issue = 1'b0; rt_addr = 5'd17;
    push_exp(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk); pop_check("issued");
    chk("rs_busy_set", 32'(rs_busy), 32'd1);
    chk("rt_busy_set", 32'(rt_busy), 32'd1);
    next_cycle();
    rt_addr = 5'd0;
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 32'h7777);
    md_issue = 1'b1; md_issue_reg = 5'd17;
    push_exp(1'b1, 5'd17, 32'h7777, 1'b1, 1'b0);
    @(negedge clk); pop_check("hs_and_issue"); chk("rt_zero_addr", 32'(rt_busy), 32'd0); next_cycle();
    md_issue = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    push_exp(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk); pop_check("idle1"); chk("set_wins", 32'(rs_busy), 32'd1); next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 32'h8888);
    push_exp(1'b1, 5'd17, 32'h8888, 1'b1, 1'b0);
    @(negedge clk); pop_check("hs_17"); next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    push_exp(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk); pop_check("idle2"); chk("busy_cleared", 32'(rs_busy), 32'd0); next_cycle();

    // MD result to $0 is accepted without a write
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h9999);
    push_exp(1'b0, 5'd0, 32'h9999, 1'b1, 1'b0);
    @(negedge clk); pop_check("md_zero");
`ifdef REGFILE_ARB_STATS_EN
    chk("md_grant_cnt", md_grant_cnt, 32'd6);
`else
    chk("md_grant_cnt_tied", md_grant_cnt, 32'd0);
`endif
    next_cycle();

    // Reach FORCE again with reg 20 pending, then reset in the middle of it
    rs_addr = 5'd20;
    md_issue = 1'b1; md_issue_reg = 5'd20;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 5'd9, 32'hD000 + 32'(i), 1'b1, 5'd7, 32'h7070);
      push_exp(1'b1, 5'd9, 32'hD000 + 32'(i), 1'b0, 1'b0);
      @(negedge clk); pop_check("starve2_wb"); next_cycle();
      md_issue = 1'b0;
    end
    push_exp(1'b1, 5'd7, 32'h7070, 1'b1, 1'b1);
    @(negedge clk); pop_check("starve2_force");
    chk("busy20_before_reset", 32'(rs_busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst.md_ready", 32'(md_ready), 32'd0);
    chk("rst.wb_stall", 32'(wb_stall), 32'd0);
    chk("rst.rf_we",    32'(rf_we),    32'd0);
    chk("rst.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst.rf_wdata", rf_wdata,      32'd0);
    chk("rst.rs_busy",  32'(rs_busy),  32'd0);
    next_cycle();
    reset = 1'b1;
    set_in(1'b1, 5'd9, 32'hE000, 1'b1, 5'd7, 32'h7070);
    push_exp(1'b1, 5'd9, 32'hE000, 1'b0, 1'b0);
    @(negedge clk); pop_check("post_reset_idle");
    chk("post_reset_busy", 32'(rs_busy), 32'd0);
    chk("post_reset_stall_cnt", stall_cnt, 32'd0);
    chk("post_reset_grant_cnt", md_grant_cnt, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
